cmd_frame_parser: RTL and testbench

CMD_FRAME_PARSER -- requirements
Module: cmd_frame_parser

---
 rtl/cmd_frame_parser.sv | 120 ++++++++++++
 tb/tb_cmd_frame_parser.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_frame_parser.sv
// Parses 4-byte command frames (SYNC, ADDR, DATA, CHK) from a byte stream and
// issues a registered write strobe for good frames or an error pulse otherwise.
module cmd_frame_parser #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 50000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic [7:0] ADDRESS,
  output logic [7:0] DATA,
  output logic       ENA,
  output logic       FRM_ERR,
  output logic [7:0] ERR_CNT
);

  localparam int unsigned GAP_W = 20;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } state_e;

  state_e           state_q,   state_d;
  logic [GAP_W-1:0] gap_q,     gap_d;
  logic [7:0]       addr_sh_q, addr_sh_d;
  logic [7:0]       data_sh_q, data_sh_d;
  logic [7:0]       address_q, address_d;
  logic [7:0]       data_q,    data_d;
  logic             ena_q,     ena_d;
  logic             frm_err_q, frm_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  // Next-state, shadow capture, output update and gap timer
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    addr_sh_d = addr_sh_q;
    data_sh_d = data_sh_q;
    address_d = address_q;
    data_d    = data_q;
    ena_d     = 1'b0;
    frm_err_d = 1'b0;
    err_cnt_d = err_cnt_q;

    if (RX_VALID || state_q == S_IDLE) begin
      gap_d = '0;
    end else begin
      gap_d = gap_q + GAP_W'(1);
    end

    // A byte arriving on the timeout cycle wins over the timeout
    if (RX_VALID) begin
      case (state_q)
        S_IDLE: if (RX_DATA == SYNC_BYTE) state_d = S_ADDR;
        S_ADDR: begin
          addr_sh_d = RX_DATA;
          state_d   = S_DATA;
        end
        S_DATA: begin
          data_sh_d = RX_DATA;
          state_d   = S_CHK;
        end
        S_CHK: begin
          if (RX_DATA == (SYNC_BYTE ^ addr_sh_q ^ data_sh_q)) begin
            address_d = addr_sh_q;
            data_d    = data_sh_q;
            ena_d     = 1'b1;
          end else begin
            frm_err_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && gap_q == GAP_LAST) begin
      state_d   = S_IDLE;
      frm_err_d = 1'b1;
    end

    if (frm_err_d && err_cnt_q != 8'hFF) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      gap_q     <= '0;
      addr_sh_q <= '0;
      data_sh_q <= '0;
      address_q <= '0;
      data_q    <= '0;
      ena_q     <= 1'b0;
      frm_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      addr_sh_q <= addr_sh_d;
      data_sh_q <= data_sh_d;
      address_q <= address_d;
      data_q    <= data_d;
      ena_q     <= ena_d;
      frm_err_q <= frm_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ADDRESS = address_q;
  assign DATA    = data_q;
  assign ENA     = ena_q;
  assign FRM_ERR = frm_err_q;
  assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_cmd_frame_parser.sv
// Directed bench for cmd_frame_parser: inputs driven and outputs sampled on the
// falling edge, so each check sees the state registered at the previous rise.
module tb_cmd_frame_parser;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_DATA = 8'h00;
  logic       RX_VALID = 1'b0;
  logic [7:0] ADDRESS;
  logic [7:0] DATA;
  logic       ENA;
  logic       FRM_ERR;
  logic [7:0] ERR_CNT;

  int checks = 0;
  int failures = 0;

  cmd_frame_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .ADDRESS(ADDRESS), .DATA(DATA), .ENA(ENA), .FRM_ERR(FRM_ERR), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    RX_VALID = 1'b1;
    RX_DATA  = b;
  endtask

  task automatic idle();
    @(negedge CLK);
    RX_VALID = 1'b0;
    RX_DATA  = 8'h00;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({ADDRESS, DATA, ENA, FRM_ERR, ERR_CNT} !== 26'd0) begin
      failures++;
      $display("FAIL reset_state got addr=%h data=%h ena=%b err=%b cnt=%h exp all 0",
               ADDRESS, DATA, ENA, FRM_ERR, ERR_CNT);
    end
    RST = 1'b1;
  endtask

  task automatic test_good_frame();
    logic [7:0] b [4] = '{8'hA5, 8'h4D, 8'h1F, 8'hF7};
    for (int i = 0; i < 4; i++) begin
      send(b[i]);
      checks++;
      if (ENA !== 1'b0 || FRM_ERR !== 1'b0) begin
        failures++;
        $display("FAIL good_early byte%0d got ena=%b err=%b exp 0/0", i, ENA, FRM_ERR);
      end
    end
    idle();
    checks++;
    if (ENA !== 1'b1 || ADDRESS !== 8'h4D || DATA !== 8'h1F || FRM_ERR !== 1'b0) begin
      failures++;
      $display("FAIL good_strobe got ena=%b addr=%h data=%h err=%b exp 1/4d/1f/0",
               ENA, ADDRESS, DATA, FRM_ERR);
    end
    idle();
    checks++;
    if (ENA !== 1'b0 || ADDRESS !== 8'h4D || DATA !== 8'h1F) begin
      failures++;
      $display("FAIL good_hold got ena=%b addr=%h data=%h exp 0/4d/1f", ENA, ADDRESS, DATA);
    end
  endtask

  task automatic test_bad_checksum();
    send(8'hA5); send(8'h7C); send(8'h08); send(8'h00);
    idle();
    checks++;
    if (FRM_ERR !== 1'b1 || ERR_CNT !== 8'd1 || ENA !== 1'b0 ||
        ADDRESS !== 8'h4D || DATA !== 8'h1F) begin
      failures++;
      $display("FAIL bad_chk got err=%b cnt=%h ena=%b addr=%h data=%h exp 1/01/0/4d/1f",
               FRM_ERR, ERR_CNT, ENA, ADDRESS, DATA);
    end
    idle();
    checks++;
    if (FRM_ERR !== 1'b0 || ERR_CNT !== 8'd1) begin
      failures++;
      $display("FAIL bad_chk_pulse got err=%b cnt=%h exp 0/01", FRM_ERR, ERR_CNT);
    end
  endtask

  task automatic test_timeout();
    send(8'hA5); send(8'h10);
    for (int k = 1; k <= 8; k++) begin
      idle();
      checks++;
      if (FRM_ERR !== 1'b0) begin
        failures++;
        $display("FAIL timeout_early idle%0d got err=%b exp 0", k, FRM_ERR);
      end
    end
    idle();
    checks++;
    if (FRM_ERR !== 1'b1 || ERR_CNT !== 8'd2 || ENA !== 1'b0) begin
      failures++;
      $display("FAIL timeout_fire got err=%b cnt=%h ena=%b exp 1/02/0", FRM_ERR, ERR_CNT, ENA);
    end
    idle();
    checks++;
    if (FRM_ERR !== 1'b0 || ADDRESS !== 8'h4D || DATA !== 8'h1F) begin
      failures++;
      $display("FAIL timeout_after got err=%b addr=%h data=%h exp 0/4d/1f", FRM_ERR, ADDRESS, DATA);
    end
  endtask

  // Next byte lands on the cycle the gap counter reaches TIMEOUT-1
  task automatic test_byte_priority();
    send(8'hA5);
    repeat (7) idle();
    send(8'h66);
    send(8'h01);
    checks++;
    if (FRM_ERR !== 1'b0) begin
      failures++;
      $display("FAIL prio_no_timeout got err=%b exp 0", FRM_ERR);
    end
    send(8'hC2);
    idle();
    checks++;
    if (ENA !== 1'b1 || ADDRESS !== 8'h66 || DATA !== 8'h01 || FRM_ERR !== 1'b0 || ERR_CNT !== 8'd2) begin
      failures++;
      $display("FAIL prio_frame got ena=%b addr=%h data=%h err=%b cnt=%h exp 1/66/01/0/02",
               ENA, ADDRESS, DATA, FRM_ERR, ERR_CNT);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [10] = '{8'h00, 8'hFF, 8'hA5, 8'hFE, 8'h00, 8'h5B,
                           8'hA5, 8'h4E, 8'h00, 8'hEB};
    idle();
    for (int i = 0; i < 10; i++) begin
      send(b[i]);
      checks++;
      if (i == 6) begin
        if (ENA !== 1'b1 || ADDRESS !== 8'hFE || DATA !== 8'h00 || FRM_ERR !== 1'b0) begin
          failures++;
          $display("FAIL b2b_first got ena=%b addr=%h data=%h err=%b exp 1/fe/00/0",
                   ENA, ADDRESS, DATA, FRM_ERR);
        end
      end else if (ENA !== 1'b0 || FRM_ERR !== 1'b0) begin
        failures++;
        $display("FAIL b2b_quiet byte%0d got ena=%b err=%b exp 0/0", i, ENA, FRM_ERR);
      end
    end
    idle();
    checks++;
    if (ENA !== 1'b1 || ADDRESS !== 8'h4E || DATA !== 8'h00 || FRM_ERR !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second got ena=%b addr=%h data=%h err=%b exp 1/4e/00/0",
               ENA, ADDRESS, DATA, FRM_ERR);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt = 2;
    for (int f = 0; f < 300; f++) begin
      send(8'hA5); send(8'h7C); send(8'h08); send(8'h00);
      idle();
      exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
      checks++;
      if (FRM_ERR !== 1'b1 || ERR_CNT !== 8'(exp_cnt) || ENA !== 1'b0) begin
        failures++;
        $display("FAIL sat_frame%0d got err=%b cnt=%h ena=%b exp 1/%h/0",
                 f, FRM_ERR, ERR_CNT, ENA, 8'(exp_cnt));
      end
    end
    idle();
    checks++;
    if (ERR_CNT !== 8'hFF || ADDRESS !== 8'h4E || DATA !== 8'h00) begin
      failures++;
      $display("FAIL sat_final got cnt=%h addr=%h data=%h exp ff/4e/00", ERR_CNT, ADDRESS, DATA);
    end
  endtask

  task automatic test_reset_mid_frame();
    send(8'hA5); send(8'h4D);
    @(negedge CLK);
    RX_VALID = 1'b0;
    RST = 1'b0;
    #1;
    checks++;
    if ({ADDRESS, DATA, ENA, FRM_ERR, ERR_CNT} !== 26'd0) begin
      failures++;
      $display("FAIL rst_mid got addr=%h data=%h ena=%b err=%b cnt=%h exp all 0",
               ADDRESS, DATA, ENA, FRM_ERR, ERR_CNT);
    end
    @(negedge CLK);
    RST = 1'b1;
    send(8'h1F); send(8'hF7);
    for (int k = 0; k < 3; k++) begin
      idle();
      checks++;
      if (ENA !== 1'b0 || FRM_ERR !== 1'b0 || ERR_CNT !== 8'd0) begin
        failures++;
        $display("FAIL rst_tail cyc%0d got ena=%b err=%b cnt=%h exp 0/0/00", k, ENA, FRM_ERR, ERR_CNT);
      end
    end
    send(8'hA5); send(8'h4D); send(8'h1F); send(8'hF7);
    idle();
    checks++;
    if (ENA !== 1'b1 || ADDRESS !== 8'h4D || DATA !== 8'h1F) begin
      failures++;
      $display("FAIL rst_recover got ena=%b addr=%h data=%h exp 1/4d/1f", ENA, ADDRESS, DATA);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_timeout();
    test_byte_priority();
    test_back_to_back();
    test_saturation();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
